// File: rtl/hazard_u.sv
// -----------------------------------------------------------------------------
// hazard_u -- load-use hazard detection unit for an in-order RV32I pipeline.
//
// Purpose:
//   Detects the case where the instruction in ID reads a register that the
//   load currently in EX will write. When that happens, the PC and the IF/ID
//   register are held for one cycle, and a bubble is sent into ID/EX.
//   The detection path is purely combinational, with zero-cycle latency.
//
// Ports:
//   clk          in   1   rising-edge clock (only used by the stall counter)
//   rst          in   1   synchronous, active-high reset
//   R_d          in   5   destination register of the EX-stage instruction
//   MemRead      in   1   EX-stage instruction is a load
//   Instruction  in  32   raw instruction in the ID stage
//   SignalPC     out  1   1 = stall: hold PC
//   IFID_Hold    out  1   1 = hold IF/ID (same as SignalPC)
//   CtrlBubble   out  1   1 = zero ID/EX control (same as SignalPC)
//   StallCount   out 16   saturating stall-cycle count (HAZARD_STATS_EN only)
//
// Configuration:
//   HAZARD_STATS_EN -- when defined, adds the StallCount port and its
//                      saturating counter. Nothing else changes.
// -----------------------------------------------------------------------------
module hazard_u (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  R_d,
  input  logic        MemRead,
  input  logic [31:0] Instruction,
  output logic        SignalPC,
  output logic        IFID_Hold,
  output logic        CtrlBubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] StallCount
`endif
);

  // Opcodes that read source registers.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_hazard;
  logic       w_stall;

  assign w_opcode = Instruction[6:0];
  assign w_rs1    = Instruction[19:15];
  assign w_rs2    = Instruction[24:20];

  // The funct/rd/immediate bits do not matter for hazard detection.
  logic w_unused_instr;
  assign w_unused_instr = ^{Instruction[31:25], Instruction[14:7]};

  // Decode which source fields the opcode actually reads. A field that is
  // not read must never cause a stall, even when its bits match R_d.
  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_opcode)
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
      end
      default: begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
      end
    endcase
  end

  // Load-use match. x0 is never a real dependency. The OR means that
  // rs1==rs2==R_d still gives a single stall.
  always_comb begin
    w_hazard = 1'b0;
    if (MemRead && (R_d != 5'd0)) begin
      w_hazard = (w_rs1_used && (w_rs1 == R_d)) ||
                 (w_rs2_used && (w_rs2 == R_d));
    end else begin
      w_hazard = 1'b0;
    end
  end

  // Reset masks the stall combinationally. No stall state is kept: the
  // bubble reaches EX with MemRead=0, and that ends the stall on its own.
  always_comb begin
    w_stall = 1'b0;
    if (rst) begin
      w_stall = 1'b0;
    end else begin
      w_stall = w_hazard;
    end
  end

  assign SignalPC   = w_stall;
  assign IFID_Hold  = w_stall;
  assign CtrlBubble = w_stall;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_count;

  // Saturating count of stall cycles, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= 16'h0000;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'h0001;
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign StallCount = r_stall_count;
`else
  // Without the counter there is no clocked logic, so clk is not used.
  logic w_unused_clk;
  assign w_unused_clk = clk;
`endif

endmodule

// File: tb/tb_hazard_u.sv
module tb_hazard_u;

  logic        clk;
  logic        rst;
  logic [4:0]  R_d;
  logic        MemRead;
  logic [31:0] Instruction;
  logic        SignalPC;
  logic        IFID_Hold;
  logic        CtrlBubble;
`ifdef HAZARD_STATS_EN
  logic [15:0] StallCount;
`endif

  int checks;
  int failures;

  hazard_u dut (
    .clk         (clk),
    .rst         (rst),
    .R_d         (R_d),
    .MemRead     (MemRead),
    .Instruction (Instruction),
    .SignalPC    (SignalPC),
    .IFID_Hold   (IFID_Hold),
    .CtrlBubble  (CtrlBubble)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount  (StallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        mr;
    logic [31:0] instr;
    logic        rst_v;
    logic        exp;
  } vec_t;

  vec_t vecs[$];

  // Instruction with the given opcode and rs1/rs2 fields; other fields are fixed.
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] a,
                                     input logic [4:0] b);
    return {7'b0000000, b, a, 3'b000, 5'b00001, op};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk1({name, ".SignalPC"},   SignalPC,   exp);
    chk1({name, ".IFID_Hold"},  IFID_Hold,  exp);
    chk1({name, ".CtrlBubble"}, CtrlBubble, exp);
  endtask

`ifdef HAZARD_STATS_EN
  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
`endif

  task automatic drive(input logic r, input logic [4:0] rd, input logic mr,
                       input logic [31:0] ins);
    @(negedge clk);
    rst = r; R_d = rd; MemRead = mr; Instruction = ins;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; R_d = 5'd0; MemRead = 1'b0; Instruction = 32'h00000013;

    // Vector table: {R_d, MemRead, Instruction, rst, expected stall}
    vecs.push_back('{5'd10, 1'b1, 32'h8A620013, 1'b0, 1'b0}); // addi, no match
    vecs.push_back('{5'd4,  1'b1, 32'h8A620013, 1'b0, 1'b1}); // addi rs1 match
    vecs.push_back('{5'd6,  1'b1, 32'h8A620013, 1'b0, 1'b0}); // I-type rs2 bits ignored
    vecs.push_back('{5'd5,  1'b1, 32'h005100B3, 1'b0, 1'b1}); // add rs2 match
    vecs.push_back('{5'd5,  1'b0, 32'h005100B3, 1'b0, 1'b0}); // not a load
    vecs.push_back('{5'd2,  1'b1, 32'h005100B3, 1'b0, 1'b1}); // add rs1 match
    vecs.push_back('{5'd0,  1'b1, mk(7'b0110011, 5'd0, 5'd0), 1'b0, 1'b0}); // x0
    vecs.push_back('{5'd6,  1'b1, 32'h00600037, 1'b0, 1'b0}); // LUI
    vecs.push_back('{5'd3,  1'b1, mk(7'b0110011, 5'd3, 5'd3), 1'b0, 1'b1}); // rs1==rs2
    vecs.push_back('{5'd5,  1'b1, mk(7'b0110011, 5'd3, 5'd4), 1'b0, 1'b0}); // mismatch
    vecs.push_back('{5'd4,  1'b1, 32'h8A620013, 1'b1, 1'b0}); // rst masks stall
    // rs1 users
    vecs.push_back('{5'd7, 1'b1, mk(7'b0110011, 5'd7, 5'd0), 1'b0, 1'b1});
    vecs.push_back('{5'd7, 1'b1, mk(7'b0010011, 5'd7, 5'd0), 1'b0, 1'b1});
    vecs.push_back('{5'd7, 1'b1, mk(7'b0000011, 5'd7, 5'd0), 1'b0, 1'b1});
    vecs.push_back('{5'd7, 1'b1, mk(7'b0100011, 5'd7, 5'd0), 1'b0, 1'b1});
    vecs.push_back('{5'd7, 1'b1, mk(7'b1100011, 5'd7, 5'd0), 1'b0, 1'b1});
    vecs.push_back('{5'd7, 1'b1, mk(7'b1100111, 5'd7, 5'd0), 1'b0, 1'b1});
    // opcodes that read neither field
    vecs.push_back('{5'd7, 1'b1, mk(7'b0110111, 5'd7, 5'd7), 1'b0, 1'b0});
    vecs.push_back('{5'd7, 1'b1, mk(7'b0010111, 5'd7, 5'd7), 1'b0, 1'b0});
    vecs.push_back('{5'd7, 1'b1, mk(7'b1101111, 5'd7, 5'd7), 1'b0, 1'b0});
    vecs.push_back('{5'd7, 1'b1, mk(7'b1110011, 5'd7, 5'd7), 1'b0, 1'b0});
    vecs.push_back('{5'd7, 1'b1, mk(7'b0001111, 5'd7, 5'd7), 1'b0, 1'b0});
    // rs2 users / non-users
    vecs.push_back('{5'd9, 1'b1, mk(7'b0110011, 5'd0, 5'd9), 1'b0, 1'b1});
    vecs.push_back('{5'd9, 1'b1, mk(7'b0100011, 5'd0, 5'd9), 1'b0, 1'b1});
    vecs.push_back('{5'd9, 1'b1, mk(7'b1100011, 5'd0, 5'd9), 1'b0, 1'b1});
    vecs.push_back('{5'd9, 1'b1, mk(7'b0010011, 5'd0, 5'd9), 1'b0, 1'b0});
    vecs.push_back('{5'd9, 1'b1, mk(7'b0000011, 5'd0, 5'd9), 1'b0, 1'b0});
    vecs.push_back('{5'd9, 1'b1, mk(7'b1100111, 5'd0, 5'd9), 1'b0, 1'b0});

    // Reset state: a hazard is presented while rst is held.
    drive(1'b1, 5'd4, 1'b1, 32'h8A620013);
    chk_stall("reset_hold", 1'b0);
    @(posedge clk); #1;
    chk_stall("reset_hold_after_edge", 1'b0);
`ifdef HAZARD_STATS_EN
    chk16("reset_count", StallCount, 16'h0000);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_v, vecs[i].rd, vecs[i].mr, vecs[i].instr);
      chk_stall($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Load-use pair: a one-cycle stall, then the bubble brings MemRead=0.
    drive(1'b0, 5'd4, 1'b1, 32'h8A620013);
    chk_stall("seq_stall", 1'b1);
    drive(1'b0, 5'd0, 1'b0, 32'h8A620013);
    chk_stall("seq_release", 1'b0);

`ifdef HAZARD_STATS_EN
    // Counter: clear, count a single stall, then check that rst wins.
    drive(1'b1, 5'd0, 1'b0, 32'h00000013);
    @(posedge clk); #1;
    chk16("cnt_clear", StallCount, 16'h0000);
    drive(1'b0, 5'd4, 1'b1, 32'h8A620013);
    @(posedge clk); #1;
    chk16("cnt_one", StallCount, 16'h0001);
    drive(1'b0, 5'd0, 1'b0, 32'h8A620013);
    @(posedge clk); #1;
    chk16("cnt_hold", StallCount, 16'h0001);
    drive(1'b1, 5'd4, 1'b1, 32'h8A620013);
    chk_stall("cnt_rst_mask", 1'b0);
    @(posedge clk); #1;
    chk16("cnt_rst_clear", StallCount, 16'h0000);
    // Saturation: hold the hazard long enough to fill the counter, then once more.
    drive(1'b0, 5'd4, 1'b1, 32'h8A620013);
    repeat (65535) @(posedge clk);
    #1;
    chk16("cnt_full", StallCount, 16'hFFFF);
    @(posedge clk); #1;
    chk16("cnt_saturate", StallCount, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
